operand_stage_sb: RTL

- Parametrised successor to the decode/operand-fetch stage.
- Takes already-decoded register indices from the instruction decoder and reads operands from internal integer and vector register files, with write-back bypass.
- Tracks pending writes in a scoreboard and stalls on data hazards through a valid/ready handshake.
- Registers the issued instruction into the ID/EX pipeline register, with flush support. It sits between the decoder and the integer/vector ALUs.

---
 rtl/operand_stage_sb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/operand_stage_sb.sv
// rtl/operand_stage_sb.sv - operand fetch stage with scoreboard hazard stall and ID/EX register
module operand_stage_sb #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8,
  parameter int CTRL_W    = 24,
  parameter int PC_REG    = 15,
  parameter int STALL_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [REGI_SIZE-1:0]           pc_i,
  input  logic [CTRL_W-1:0]              ctrl_i,
  input  logic [2*REGI_BITS-1:0]         int_src_i,
  input  logic [1:0]                     int_src_en_i,
  input  logic [2*VECT_BITS-1:0]         vec_src_i,
  input  logic [1:0]                     vec_src_en_i,
  input  logic [REGI_BITS-1:0]           int_dst_i,
  input  logic                           int_dst_en_i,
  input  logic [VECT_BITS-1:0]           vec_dst_i,
  input  logic                           vec_dst_en_i,
  input  logic                           int_we_i,
  input  logic [REGI_BITS-1:0]           int_wa_i,
  input  logic [REGI_SIZE-1:0]           int_wd_i,
  input  logic                           vec_we_i,
  input  logic [VECT_BITS-1:0]           vec_wa_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_i,
  input  logic                           flush_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [REGI_SIZE-1:0]           intOper1_o,
  output logic [REGI_SIZE-1:0]           intOper2_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vOper1_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vOper2_o,
  output logic [REGI_SIZE-1:0]           pc_o,
  output logic [CTRL_W-1:0]              ctrl_o,
  output logic [REGI_BITS-1:0]           int_dst_o,
  output logic                           int_dst_en_o,
  output logic [VECT_BITS-1:0]           vec_dst_o,
  output logic                           vec_dst_en_o,
  output logic [STALL_W-1:0]             stall_cnt_o
);

  localparam int NREG = 1 << REGI_BITS;
  localparam int NVEC = 1 << VECT_BITS;
  localparam int VW   = ELEM_SIZE * VECT_SIZE;
  localparam logic [REGI_BITS-1:0] PC_IDX = REGI_BITS'(PC_REG);

  logic [REGI_SIZE-1:0] int_rf [NREG];
  logic [VW-1:0]        vec_rf [NVEC];
  logic [NREG-1:0]      int_busy, int_set, int_clr;
  logic [NVEC-1:0]      vec_busy, vec_set, vec_clr;

  logic [REGI_BITS-1:0] isrc1, isrc2;
  logic [VECT_BITS-1:0] vsrc1, vsrc2;
  logic [REGI_SIZE-1:0] iop1, iop2;
  logic [VW-1:0]        vop1, vop2;
  logic                 hazard;
  logic                 issue;

  assign isrc1 = int_src_i[REGI_BITS-1:0];
  assign isrc2 = int_src_i[2*REGI_BITS-1:REGI_BITS];
  assign vsrc1 = vec_src_i[VECT_BITS-1:0];
  assign vsrc2 = vec_src_i[2*VECT_BITS-1:VECT_BITS];

  // Operand read: PC index overrides everything, then write-back bypass, then storage
  always_comb begin
    iop1 = int_rf[isrc1];
    iop2 = int_rf[isrc2];
    vop1 = vec_rf[vsrc1];
    vop2 = vec_rf[vsrc2];
    if (int_we_i && int_wa_i == isrc1) iop1 = int_wd_i;
    if (int_we_i && int_wa_i == isrc2) iop2 = int_wd_i;
    if (isrc1 == PC_IDX) iop1 = pc_i;
    if (isrc2 == PC_IDX) iop2 = pc_i;
    if (vec_we_i && vec_wa_i == vsrc1) vop1 = vec_wd_i;
    if (vec_we_i && vec_wa_i == vsrc2) vop2 = vec_wd_i;
  end

  // Hazard: a needed register is busy and its result is not arriving this cycle
  always_comb begin
    hazard = 1'b0;
    if (int_src_en_i[0] && isrc1 != PC_IDX && int_busy[isrc1] &&
        !(int_we_i && int_wa_i == isrc1)) hazard = 1'b1;
    if (int_src_en_i[1] && isrc2 != PC_IDX && int_busy[isrc2] &&
        !(int_we_i && int_wa_i == isrc2)) hazard = 1'b1;
    if (vec_src_en_i[0] && vec_busy[vsrc1] &&
        !(vec_we_i && vec_wa_i == vsrc1)) hazard = 1'b1;
    if (vec_src_en_i[1] && vec_busy[vsrc2] &&
        !(vec_we_i && vec_wa_i == vsrc2)) hazard = 1'b1;
    if (int_dst_en_i && int_busy[int_dst_i] &&
        !(int_we_i && int_wa_i == int_dst_i)) hazard = 1'b1;
    if (vec_dst_en_i && vec_busy[vec_dst_i] &&
        !(vec_we_i && vec_wa_i == vec_dst_i)) hazard = 1'b1;
  end

  assign in_ready_o = rst && !hazard && !flush_i && (!out_valid_o || out_ready_i);
  assign issue      = in_valid_i && in_ready_o;

  // Scoreboard set/clear masks; a flushed entry gives back its destination
  always_comb begin
    int_set = '0;
    int_clr = '0;
    vec_set = '0;
    vec_clr = '0;
    if (issue && int_dst_en_i) int_set[int_dst_i] = 1'b1;
    if (issue && vec_dst_en_i) vec_set[vec_dst_i] = 1'b1;
    if (int_we_i) int_clr[int_wa_i] = 1'b1;
    if (vec_we_i) vec_clr[vec_wa_i] = 1'b1;
    if (flush_i && out_valid_o && int_dst_en_o) int_clr[int_dst_o] = 1'b1;
    if (flush_i && out_valid_o && vec_dst_en_o) vec_clr[vec_dst_o] = 1'b1;
  end

  // Register files and busy bits; a same-cycle set beats a clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) int_rf[i] <= '0;
      for (int i = 0; i < NVEC; i++) vec_rf[i] <= '0;
      int_busy <= '0;
      vec_busy <= '0;
    end else begin
      if (int_we_i) int_rf[int_wa_i] <= int_wd_i;
      if (vec_we_i) vec_rf[vec_wa_i] <= vec_wd_i;
      int_busy <= (int_busy & ~int_clr) | int_set;
      vec_busy <= (vec_busy & ~vec_clr) | vec_set;
    end
  end

  // ID/EX register: load on issue, drop when consumed or flushed, else hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_o  <= 1'b0;
      intOper1_o   <= '0;
      intOper2_o   <= '0;
      vOper1_o     <= '0;
      vOper2_o     <= '0;
      pc_o         <= '0;
      ctrl_o       <= '0;
      int_dst_o    <= '0;
      int_dst_en_o <= 1'b0;
      vec_dst_o    <= '0;
      vec_dst_en_o <= 1'b0;
    end else if (issue) begin
      out_valid_o  <= 1'b1;
      intOper1_o   <= iop1;
      intOper2_o   <= iop2;
      vOper1_o     <= vop1;
      vOper2_o     <= vop2;
      pc_o         <= pc_i;
      ctrl_o       <= ctrl_i;
      int_dst_o    <= int_dst_i;
      int_dst_en_o <= int_dst_en_i;
      vec_dst_o    <= vec_dst_i;
      vec_dst_en_o <= vec_dst_en_i;
    end else if (flush_i || out_ready_i) begin
      out_valid_o  <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was held back
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (in_valid_i && !in_ready_o && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule
